// File: rtl/axi_skid_fifo.sv
// axi_skid_fifo: fully registered circular-buffer skid FIFO for valid/ready channels
module axi_skid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                  i_axi_aclk,
  input  logic                  i_axi_aresetn,
  input  logic                  i_flush,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [CW-1:0]         o_rd_count,
  output logic                  o_almost_full
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp, wp_nxt, rp_nxt;
  logic [CW-1:0] cnt;
  logic wr_xfer, rd_xfer;
  assign wr_xfer = i_wr_valid & o_wr_ready;
  assign rd_xfer = o_rd_valid & i_rd_ready;
  assign wp_nxt = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
  assign rp_nxt = (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
  assign o_wr_ready = cnt != CW'(DEPTH);
  assign o_rd_valid = cnt != '0;
  assign o_rd_data = mem[rp];
  assign o_rd_count = cnt;
  assign o_almost_full = cnt >= CW'(AF_LEVEL);
  always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn)
    if (!i_axi_aresetn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_xfer) begin
        mem[wp] <= i_wr_data;
        wp <= wp_nxt;
      end
      if (rd_xfer) rp <= rp_nxt;
      cnt <= cnt + CW'(wr_xfer) - CW'(rd_xfer);
    end
endmodule

// File: tb/tb_axi_skid_fifo.sv
// tb_axi_skid_fifo: scoreboard bench over DEPTH=4/3/5 instances of axi_skid_fifo
module tb_axi_skid_fifo;
  logic clk = 0, rstn = 0;
  logic fl_a = 0, wv_a = 0, rr_a = 0, wr_a, rv_a, af_a;
  logic fl_b = 0, wv_b = 0, rr_b = 0, wr_b, rv_b, af_b;
  logic fl_c = 0, wv_c = 0, rr_c = 0, wr_c, rv_c, af_c;
  logic [31:0] wd_a = 0, wd_b = 0, wd_c = 0, rd_a, rd_b, rd_c;
  logic [2:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;
  logic [31:0] qa[$], qb[$], qc[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi_skid_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AF_LEVEL(3)) u_a (
    .i_axi_aclk(clk), .i_axi_aresetn(rstn), .i_flush(fl_a), .i_wr_valid(wv_a), .o_wr_ready(wr_a),
    .i_wr_data(wd_a), .o_rd_valid(rv_a), .i_rd_ready(rr_a), .o_rd_data(rd_a), .o_rd_count(cnt_a),
    .o_almost_full(af_a));
  axi_skid_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_b (
    .i_axi_aclk(clk), .i_axi_aresetn(rstn), .i_flush(fl_b), .i_wr_valid(wv_b), .o_wr_ready(wr_b),
    .i_wr_data(wd_b), .o_rd_valid(rv_b), .i_rd_ready(rr_b), .o_rd_data(rd_b), .o_rd_count(cnt_b),
    .o_almost_full(af_b));
  axi_skid_fifo #(.DATA_WIDTH(32), .DEPTH(5)) u_c (
    .i_axi_aclk(clk), .i_axi_aresetn(rstn), .i_flush(fl_c), .i_wr_valid(wv_c), .o_wr_ready(wr_c),
    .i_wr_data(wd_c), .o_rd_valid(rv_c), .i_rd_ready(rr_c), .o_rd_data(rd_c), .o_rd_count(cnt_c),
    .o_almost_full(af_c));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pop(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: output %0h with empty scoreboard", name, act);
    end else chk(name, act, q.pop_front());
  endtask
  always @(negedge clk) begin
    if (rstn && rv_a && rr_a) pop("a_data", rd_a, qa);
    if (rstn && rv_b && rr_b) pop("b_data", rd_b, qb);
    if (rstn && rv_c && rr_c) pop("c_data", rd_c, qc);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int mc;
    logic wacc, racc;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1;
    @(negedge clk);
    chk("rst_wr_ready", wr_a, 1);
    chk("rst_rd_valid", rv_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_rd_data", rd_a, 0);
    chk("rst_af", af_a, 0);
    chk("rst_b_valid", rv_b, 0);
    chk("rst_c_count", cnt_c, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      wv_a = 1;
      wd_a = 32'hA0 + i;
      @(negedge clk);
      chk("fill_count", cnt_a, i > 4 ? 4 : i);
      chk("fill_af", af_a, i >= 3);
      chk("fill_wr_ready", wr_a, i < 4);
      if (i > 0) chk("fill_hold_data", rd_a, 32'hA0);
      if (i < 4) qa.push_back(wd_a);
      step();
    end
    @(negedge clk);
    chk("full_held_count", cnt_a, 4);
    step();
    wv_a = 0;
    rr_a = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", rv_a, 1);
      chk("drain_count", cnt_a, 4 - i);
      step();
    end
    @(negedge clk);
    chk("drain_empty_valid", rv_a, 0);
    chk("drain_empty_count", cnt_a, 0);
    step();
    rr_a = 0;
    rr_b = 1;
    for (int i = 0; i < 20; i++) begin
      wv_b = 1;
      wd_b = i;
      @(negedge clk);
      chk("stream_count", cnt_b, i == 0 ? 0 : 1);
      chk("stream_wr_ready", wr_b, 1);
      qb.push_back(wd_b);
      step();
    end
    wv_b = 0;
    step();
    @(negedge clk);
    chk("stream_end_count", cnt_b, 0);
    chk("stream_q_empty", qb.size(), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      wv_a = 1;
      wd_a = 32'hB0 + i;
      @(negedge clk);
      qa.push_back(wd_a);
      step();
    end
    fl_a = 1;
    wd_a = 32'hFF;
    @(negedge clk);
    chk("preflush_count", cnt_a, 3);
    qa.delete();
    step();
    fl_a = 0;
    wv_a = 0;
    @(negedge clk);
    chk("flush_count", cnt_a, 0);
    chk("flush_valid", rv_a, 0);
    chk("flush_wr_ready", wr_a, 1);
    step();
    wv_a = 1;
    wd_a = 32'h55;
    @(negedge clk);
    qa.push_back(wd_a);
    step();
    wv_a = 0;
    rr_a = 1;
    step();
    step();
    rr_a = 0;
    chk("flush_q_empty", qa.size(), 0);
    mc = 0;
    for (int i = 0; i < 1000; i++) begin
      wv_c = 1'($urandom_range(0, 1));
      rr_c = 1'($urandom_range(0, 1));
      wd_c = $urandom;
      @(negedge clk);
      chk("rand_count", cnt_c, mc);
      chk("rand_wr_ready", wr_c, mc != 5);
      chk("rand_rd_valid", rv_c, mc != 0);
      wacc = wv_c && mc != 5;
      racc = rr_c && mc != 0;
      if (wacc) qc.push_back(wd_c);
      mc = mc + int'(wacc) - int'(racc);
      step();
    end
    wv_c = 0;
    rr_c = 1;
    repeat (6) step();
    @(negedge clk);
    chk("rand_drain_count", cnt_c, 0);
    chk("rand_q_empty", qc.size(), 0);
    rr_c = 0;
    step();
    wv_a = 1;
    wd_a = 32'h77;
    step();
    wv_a = 0;
    @(negedge clk);
    chk("pre_areset_count", cnt_a, 1);
    rstn = 0;
    #1;
    chk("areset_valid", rv_a, 0);
    chk("areset_count", cnt_a, 0);
    chk("areset_data", rd_a, 0);
    chk("areset_wr_ready", wr_a, 1);
    qa.delete();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_skid_fifo.md
# axi_skid_fifo

Parametrised circular-buffer skid stage for AXI/AXI-Stream style valid/ready channels, generalising the fixed shift-register skid buffer to any depth 2..16, with occupancy, almost-full and synchronous flush. It sits between a producer and a consumer on any AXI channel (AW/W/AR/R/B payloads packed into DATA_WIDTH). It fully registers the handshake: no combinational path from i_wr_valid/i_wr_data to the output side, and none from i_rd_ready to o_wr_ready.

## Interface
- DATA_WIDTH, 32, payload width in bits (1..1024)
- DEPTH, 4, number of storage entries (2..16, any integer; not restricted to powers of two)
- AF_LEVEL, DEPTH-1, o_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived; not overridden)
- i_axi_aclk  in  1  clock, all logic on rising edge
- i_axi_aresetn  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous clear of all stored entries
- i_wr_valid  in  1  producer valid
- o_wr_ready  out  1  buffer can accept
- i_wr_data  in  DATA_WIDTH  producer payload
- o_rd_valid  out  1  buffer holds at least one entry
- i_rd_ready  in  1  consumer ready
- o_rd_data  out  DATA_WIDTH  oldest stored entry
- o_rd_count  out  CW  current occupancy 0..DEPTH
- o_almost_full  out  1  occupancy >= AF_LEVEL

## Operation
- Storage: DEPTH x DATA_WIDTH register array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, min 1), occupancy counter cnt (CW bits).
- wr_xfer = i_wr_valid & o_wr_ready; rd_xfer = o_rd_valid & i_rd_ready.
- wr_xfer: mem[wp] <= i_wr_data; wp advances. rd_xfer: rp advances.
- Pointer wrap: pointer equal to DEPTH-1 advances to 0 (explicit compare; required for non-power-of-two DEPTH).
- cnt: +1 on wr_xfer only, -1 on rd_xfer only, unchanged on both or neither.
- o_wr_ready = (cnt != DEPTH); o_rd_valid = (cnt != 0); both decoded from registered cnt only.
- o_rd_data = mem[rp]; o_rd_count = cnt; o_almost_full = (cnt >= AF_LEVEL).
- Flush: i_flush high at a rising edge sets wp=rp=cnt=0; overrides any wr_xfer/rd_xfer in that cycle (the write is dropped, the read is still a completed handshake from the consumer's view). Memory contents are not cleared by flush.
- Ordering: strict FIFO; no entry is ever lost or duplicated outside flush.

## Timing
- Reset (async assert, sync deassert by system): wp=rp=cnt=0, mem all 0; hence o_wr_ready=1, o_rd_valid=0, o_rd_data=0, o_rd_count=0, o_almost_full=0 (AF_LEVEL>=1).
- Latency: entry written at edge N is presented with o_rd_valid=1 in the cycle after edge N (1 cycle, empty buffer).
- Throughput: 1 transfer/cycle sustained for any cnt in 1..DEPTH-1; simultaneous read and write keep cnt constant.
- Full (cnt=DEPTH): o_wr_ready=0; a read at edge N restores o_wr_ready=1 after edge N; a write presented in the full cycle is not accepted and must be held by the producer (AXI rule).
- Empty (cnt=0): o_rd_valid=0, rd_xfer impossible; a write in that cycle yields cnt=1.
- Simultaneous write and read at cnt=1: read takes old entry, new entry becomes head next cycle, o_rd_valid stays 1.
- o_rd_valid/o_rd_data stable while o_rd_valid=1 and i_rd_ready=0 (until flush or reset).
- Reset mid-operation: all state cleared immediately on aresetn falling, independent of clock.

## Test plan
- Reset, DEPTH=4: hold aresetn low 3 cycles -> o_wr_ready=1, o_rd_valid=0, o_rd_count=0, o_rd_data=0, o_almost_full=0.
- Fill, DEPTH=4, AF_LEVEL=3, i_rd_ready=0: write 0xA0..0xA3 back-to-back -> o_rd_count 1,2,3,4; o_almost_full high from count 3; o_wr_ready=0 after 4th; 5th write 0xA4 held, not accepted.
- Drain after fill: i_rd_ready=1, i_wr_valid=0 -> o_rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, then o_rd_valid=0, count 0.
- Streaming, DEPTH=3 (non-power-of-two): 20 consecutive writes 0..19 with i_rd_ready=1 always -> reads 0..19 in order, one per cycle, count constant at 1, pointers wrap at 2->0.
- Random backpressure, DEPTH=5: random i_wr_valid/i_rd_ready 50% for 1000 cycles -> scoreboard order exact, count matches model every cycle, never >5.
- Flush: load 3 entries, assert i_flush with concurrent i_wr_valid=1 data 0xFF -> next cycle count=0, o_rd_valid=0, 0xFF never appears at output.
